// File: rtl/phase_sequencer.sv
// Phase-strobe sequencer for the SIMPLE processor: front-panel button debounce,
// run/step/halt control, IN-instruction stall and retired-instruction counting.

module phase_sequencer_debounce #(
  parameter int DEBOUNCE_LEN = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);
  localparam int              DB_W    = (DEBOUNCE_LEN > 1) ? $clog2(DEBOUNCE_LEN) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_LEN - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic            sync1_r;
  logic            sync2_r;
  logic            level_r;
  logic            level_d_r;
  logic [DB_W-1:0] cnt_r;

  // synchronizer, stability counter and accepted-level history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r   <= 1'b0;
      sync2_r   <= 1'b0;
      level_r   <= 1'b0;
      level_d_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      sync1_r   <= button;
      sync2_r   <= sync1_r;
      level_d_r <= level_r;
      if (sync2_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == DB_LAST) begin
        level_r <= sync2_r;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + DB_ONE;
      end
    end
  end

  assign press = level_r & ~level_d_r;
endmodule

module phase_sequencer #(
  parameter int DEBOUNCE_LEN = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exec,
  input  logic             step,
  input  logic             halt,
  input  logic             in_wait,
  input  logic             in_valid,
  output logic             in_ack,
  output logic             p1,
  output logic             p2,
  output logic             p3,
  output logic             p3to4,
  output logic             p4,
  output logic             p5,
  output logic             systemRunning,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SL_S1  = 3'd0,
    SL_S2  = 3'd1,
    SL_S3  = 3'd2,
    SL_S34 = 3'd3,
    SL_S4  = 3'd4,
    SL_S5  = 3'd5
  } slot_t;

  localparam logic [CNT_W-1:0] RET_ONE = CNT_W'(1);

  function automatic slot_t next_slot(input slot_t cur);
    case (cur)
      SL_S1:   next_slot = SL_S2;
      SL_S2:   next_slot = SL_S3;
      SL_S3:   next_slot = SL_S34;
      SL_S34:  next_slot = SL_S4;
      SL_S4:   next_slot = SL_S5;
      default: next_slot = SL_S1;
    endcase
  endfunction

  state_t           state_r, state_nxt_s;
  slot_t            slot_r, slot_nxt_s;
  logic             stop_req_r, stop_nxt_s;
  logic             ret_step_r, ret_step_nxt_s;
  logic             exec_press_s, step_press_s;
  logic             active_nxt_s;
  logic             p1_nxt_s, p2_nxt_s, p3_nxt_s, p34_nxt_s, p4_nxt_s, p5_nxt_s;
  logic             running_nxt_s;
  logic             in_ack_s;
  logic [CNT_W-1:0] retired_nxt_s;
  logic             p1_r, p2_r, p3_r, p34_r, p4_r, p5_r, running_r;
  logic [CNT_W-1:0] retired_r;

  phase_sequencer_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_exec_db (
    .clock (clock),
    .reset (reset),
    .button(exec),
    .press (exec_press_s)
  );

  phase_sequencer_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_step_db (
    .clock (clock),
    .reset (reset),
    .button(step),
    .press (step_press_s)
  );

  // state, slot and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      slot_r     <= SL_S1;
      stop_req_r <= 1'b0;
      ret_step_r <= 1'b0;
      p1_r       <= 1'b0;
      p2_r       <= 1'b0;
      p3_r       <= 1'b0;
      p34_r      <= 1'b0;
      p4_r       <= 1'b0;
      p5_r       <= 1'b0;
      running_r  <= 1'b0;
      retired_r  <= '0;
    end else begin
      state_r    <= state_nxt_s;
      slot_r     <= slot_nxt_s;
      stop_req_r <= stop_nxt_s;
      ret_step_r <= ret_step_nxt_s;
      p1_r       <= p1_nxt_s;
      p2_r       <= p2_nxt_s;
      p3_r       <= p3_nxt_s;
      p34_r      <= p34_nxt_s;
      p4_r       <= p4_nxt_s;
      p5_r       <= p5_nxt_s;
      running_r  <= running_nxt_s;
      retired_r  <= retired_nxt_s;
    end
  end

  // next state and slot
  always_comb begin
    state_nxt_s    = state_r;
    slot_nxt_s     = slot_r;
    stop_nxt_s     = stop_req_r;
    ret_step_nxt_s = ret_step_r;
    case (state_r)
      ST_IDLE: begin
        slot_nxt_s = SL_S1;
        stop_nxt_s = 1'b0;
        if (exec_press_s) begin
          state_nxt_s = ST_RUN;
        end else if (step_press_s) begin
          state_nxt_s = ST_STEP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN, ST_STEP: begin
        if (exec_press_s) begin
          stop_nxt_s = 1'b1;
        end else begin
          stop_nxt_s = stop_req_r;
        end
        if ((slot_r == SL_S3) && in_wait) begin
          state_nxt_s    = ST_WAIT;
          slot_nxt_s     = SL_S34;
          ret_step_nxt_s = (state_r == ST_STEP);
        end else if (slot_r == SL_S5) begin
          slot_nxt_s = SL_S1;
          // a press landing on S5 itself counts as a stop request for this instruction
          if ((state_r == ST_STEP) || halt || stop_req_r || exec_press_s) begin
            state_nxt_s = ST_IDLE;
            stop_nxt_s  = 1'b0;
          end else begin
            state_nxt_s = state_r;
          end
        end else begin
          slot_nxt_s = next_slot(slot_r);
        end
      end
      ST_WAIT: begin
        slot_nxt_s = SL_S34;
        if (exec_press_s) begin
          state_nxt_s = ST_IDLE;
          slot_nxt_s  = SL_S1;
          stop_nxt_s  = 1'b0;
        end else if (in_valid) begin
          state_nxt_s = ret_step_r ? ST_STEP : ST_RUN;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        slot_nxt_s  = SL_S1;
        stop_nxt_s  = 1'b0;
      end
    endcase
  end

  // output decode from the upcoming state and slot, plus the combinational in_ack
  always_comb begin
    active_nxt_s  = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_STEP);
    p1_nxt_s      = active_nxt_s && (slot_nxt_s == SL_S1);
    p2_nxt_s      = active_nxt_s && (slot_nxt_s == SL_S2);
    p3_nxt_s      = active_nxt_s && (slot_nxt_s == SL_S3);
    p34_nxt_s     = active_nxt_s && ((slot_nxt_s == SL_S34) || (slot_nxt_s == SL_S4));
    p4_nxt_s      = active_nxt_s && (slot_nxt_s == SL_S4);
    p5_nxt_s      = active_nxt_s && (slot_nxt_s == SL_S5);
    running_nxt_s = (state_nxt_s != ST_IDLE);
    if (p5_nxt_s) begin
      retired_nxt_s = retired_r + RET_ONE;
    end else begin
      retired_nxt_s = retired_r;
    end
    if ((state_r == ST_WAIT) && in_valid && !exec_press_s) begin
      in_ack_s = 1'b1;
    end else begin
      in_ack_s = 1'b0;
    end
  end

  assign in_ack        = in_ack_s;
  assign p1            = p1_r;
  assign p2            = p2_r;
  assign p3            = p3_r;
  assign p3to4         = p34_r;
  assign p4            = p4_r;
  assign p5            = p5_r;
  assign systemRunning = running_r;
  assign retired       = retired_r;
endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: stimulus pushes the expected output
// events per cycle, a negedge monitor pops and compares them.

module tb_phase_sequencer;
  localparam int DEB = 16;
  localparam int CW  = 8;   // narrow counter so the wrap is reachable quickly

  logic          clock = 1'b0;
  logic          reset, exec, step, halt, in_wait, in_valid;
  logic          in_ack, p1, p2, p3, p3to4, p4, p5, systemRunning;
  logic [CW-1:0] retired;
  logic [7:0]    mon_vec;

  typedef struct {
    int            cyc;
    logic [7:0]    vec;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   ret_m    = 0;
  int   ex_on    = -100, ex_off = -100, st_on = -100, st_off = -100;
  logic is_s;

  // vector bits: in_ack, running, p1, p2, p3, p3to4, p4, p5
  localparam logic [7:0] V_P1 = 8'h60, V_P2 = 8'h50, V_P3 = 8'h48, V_P34 = 8'h44;
  localparam logic [7:0] V_P4 = 8'h46, V_P5 = 8'h41, V_STALL = 8'h40, V_ACK = 8'hC0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  assign mon_vec = {in_ack, systemRunning, p1, p2, p3, p3to4, p4, p5};

  phase_sequencer #(.DEBOUNCE_LEN(DEB), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .exec(exec), .step(step), .halt(halt),
    .in_wait(in_wait), .in_valid(in_valid), .in_ack(in_ack), .p1(p1), .p2(p2),
    .p3(p3), .p3to4(p3to4), .p4(p4), .p5(p5), .systemRunning(systemRunning),
    .retired(retired)
  );

  always @(negedge clock) begin : monitor
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_event at cyc=%0d: actual none, required vec=%h for cyc %0d", cyc, e.vec, e.cyc);
    end
    if (mon_vec !== 8'h00) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output cyc=%0d: actual vec=%h, required none", cyc, mon_vec);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.vec !== mon_vec || e.ret !== retired) begin
          failures++;
          $display("FAIL event: actual cyc=%0d vec=%h retired=%0d, required cyc=%0d vec=%h retired=%0d",
                   cyc, mon_vec, retired, e.cyc, e.vec, e.ret);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
    exec     = (cyc >= ex_on) && (cyc < ex_off);
    step     = (cyc >= st_on) && (cyc < st_off);
    halt     = 1'($urandom_range(0, 1));
    in_wait  = 1'($urandom_range(0, 1));
    in_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic expect_ev(input logic [7:0] v);
    exp_t e;
    e.cyc = cyc;
    e.vec = v;
    e.ret = CW'(ret_m);
    exp_q.push_back(e);
  endtask

  // raise the button(s) for 20 cycles; the first strobe is due 19 cycles after the rise
  task automatic press(input bit use_exec, input bit use_step);
    next_cycle();
    if (use_exec) begin ex_on = cyc; ex_off = cyc + 20; exec = 1'b1; end
    if (use_step) begin st_on = cyc; st_off = cyc + 20; step = 1'b1; end
    repeat (18) next_cycle();
  endtask

  // instruction-level model: six strobe cycles per instruction, optional IN stall,
  // stop after the instruction that contains the stop press, halt, or single step
  task automatic run_prog(input bit is_step, input int halt_idx, input int wait_idx,
                          input int wait_len, input bit abort_wait, input int stop_idx,
                          input int rst_idx);
    int idx = 0;
    int pe  = -1;
    bit done = 1'b0;
    while (!done) begin
      int start_c;
      next_cycle(); start_c = cyc; expect_ev(V_P1);
      next_cycle(); expect_ev(V_P2);
      if (idx == stop_idx) begin
        ex_on = cyc; ex_off = cyc + 20; exec = 1'b1; pe = cyc + 18;
      end
      next_cycle(); expect_ev(V_P3);
      in_wait = (idx == wait_idx);
      if (idx == wait_idx && !abort_wait && wait_len == 0) in_valid = 1'b1;
      if (idx == wait_idx) begin
        if (abort_wait) begin
          next_cycle(); in_valid = 1'b0;
          ex_on = cyc; ex_off = cyc + 20; exec = 1'b1;
          expect_ev(V_STALL);
          repeat (18) begin next_cycle(); in_valid = 1'b0; expect_ev(V_STALL); end
          done = 1'b1;
        end else begin
          repeat (wait_len) begin next_cycle(); in_valid = 1'b0; expect_ev(V_STALL); end
          next_cycle(); in_valid = 1'b1; expect_ev(V_ACK);
        end
      end
      if (!done) begin
        next_cycle(); expect_ev(V_P34);
        if (idx == rst_idx) begin
          next_cycle();
          #2 reset = 1'b0;
          #1;
          check("async_reset_outputs", {24'd0, mon_vec}, 32'd0);
          check("async_reset_retired", 32'(retired), 32'd0);
          ret_m = 0;
          done  = 1'b1;
        end else begin
          next_cycle(); expect_ev(V_P4);
          next_cycle(); ret_m++; expect_ev(V_P5);
          halt = (idx == halt_idx);
          if (is_step || idx == halt_idx || (pe >= start_c && pe <= cyc)) done = 1'b1;
          idx++;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; exec = 1'b0; step = 1'b0; halt = 1'b0; in_wait = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {24'd0, mon_vec}, 32'd0);
    check("reset_retired", 32'(retired), 32'd0);
    reset = 1'b1;
    idle(5);

    // run started by exec, halted at a random p5
    press(1'b1, 1'b0); run_prog(1'b0, $urandom_range(2, 5), -1, 0, 1'b0, -1, -1); idle(45);

    // glitchy exec never gets accepted
    for (int i = 0; i < 40; i++) begin next_cycle(); exec = (i % 5 == 0); end
    idle(25);
    check("glitch_running", 32'(systemRunning), 32'd0);
    check("glitch_retired", 32'(retired), 32'(CW'(ret_m)));

    // two single steps
    for (int i = 0; i < 2; i++) begin
      press(1'b0, 1'b1); run_prog(1'b1, -1, -1, 0, 1'b0, -1, -1); idle(45);
      check("step_running", 32'(systemRunning), 32'd0);
      check("step_retired", 32'(retired), 32'(CW'(ret_m)));
    end

    // exec and step together: exec wins, step ignored in RUN
    press(1'b1, 1'b1); run_prog(1'b0, 2, -1, 0, 1'b0, -1, -1); idle(45);

    // exec press at p2 mid-run: the instruction holding the press completes, then IDLE
    press(1'b1, 1'b0); run_prog(1'b0, -1, -1, 0, 1'b0, $urandom_range(3, 5), -1); idle(45);

    // IN stall of 7 cycles
    press(1'b1, 1'b0); run_prog(1'b0, 3, 1, 7, 1'b0, -1, -1); idle(45);

    // randomized runs and steps with stalls (length 0 means in_valid already high)
    for (int k = 0; k < 4; k++) begin
      is_s = k[0];
      press(!is_s, is_s);
      run_prog(is_s, $urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 5), 1'b0, -1, -1);
      idle(45);
    end

    // exec press during the stall aborts with no in_ack and no retire
    press(1'b1, 1'b0); run_prog(1'b0, -1, $urandom_range(3, 4), 0, 1'b1, -1, -1); idle(45);
    check("abort_running", 32'(systemRunning), 32'd0);
    check("abort_retired", 32'(retired), 32'(CW'(ret_m)));

    // counter wrap: halt one instruction after retired returns to zero
    press(1'b1, 1'b0);
    run_prog(1'b0, 256 - (ret_m % 256), -1, 0, 1'b0, -1, -1);
    idle(45);
    check("wrap_retired", 32'(retired), 32'd1);

    // asynchronous reset in the middle of S4
    press(1'b1, 1'b0); run_prog(1'b0, -1, -1, 0, 1'b0, -1, 1);
    idle(3);
    reset = 1'b1;
    idle(30);
    check("post_reset_running", 32'(systemRunning), 32'd0);
    check("post_reset_retired", 32'(retired), 32'd0);

    idle(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: actual still running at cyc=%0d, required finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
